// File: rtl/fetch_pair_unit_pkg.sv
// Shared types and constants for the dual-issue fetch stage and its instruction queue.
package fetch_pair_unit_pkg;

    localparam int          INSTR_W   = 32;
    localparam int          ADDR_W    = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] PAIR_STEP = 32'd8;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } q_entry_t;

endpackage

// File: rtl/fetch_pair_unit_if.sv
// Instruction-memory and decode-side signals of the fetch stage bundled as one interface.
interface fetch_pair_unit_if;
    import fetch_pair_unit_pkg::*;

    logic [ADDR_W-1:0]  imem_a1;
    logic [ADDR_W-1:0]  imem_a2;
    logic [INSTR_W-1:0] imem_rd1;
    logic [INSTR_W-1:0] imem_rd2;
    logic               dec_valid0;
    logic [INSTR_W-1:0] dec_instr0;
    logic [ADDR_W-1:0]  dec_pc0;
    logic               dec_valid1;
    logic [INSTR_W-1:0] dec_instr1;
    logic [ADDR_W-1:0]  dec_pc1;
    logic [1:0]         dec_take;

    modport master (
        output imem_a1, imem_a2,
        input  imem_rd1, imem_rd2,
        output dec_valid0, dec_instr0, dec_pc0,
        output dec_valid1, dec_instr1, dec_pc1,
        input  dec_take
    );

    modport slave (
        input  imem_a1, imem_a2,
        output imem_rd1, imem_rd2,
        input  dec_valid0, dec_instr0, dec_pc0,
        input  dec_valid1, dec_instr1, dec_pc1,
        output dec_take
    );

endinterface

// File: rtl/fetch_pair_queue.sv
// Circular instruction queue: writes a pair per push, exposes the two oldest entries,
// pops 0..2 per cycle, and can be flushed in one cycle.
module fetch_pair_queue
    import fetch_pair_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  q_entry_t         wr0,
    input  q_entry_t         wr1,
    input  logic [1:0]       pop,
    output q_entry_t         rd0,
    output q_entry_t         rd1,
    output logic [CNT_W-1:0] count
);

    q_entry_t         mem_q [DEPTH];
    q_entry_t         mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // The caller guarantees pop never exceeds count; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q]                = wr0;
                mem_d[tail_q + PTR_W'(1)]    = wr1;
                tail_d                       = tail_q + PTR_W'(2);
            end
            head_d  = head_q + PTR_W'(pop);
            count_d = count_q + (push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rd0   = mem_q[head_q];
    assign rd1   = mem_q[head_q + PTR_W'(1)];
    assign count = count_q;

endmodule

// File: rtl/fetch_pair_unit.sv
// Dual-issue fetch stage: owns the PC, reads two sequential words per cycle and
// buffers them for decode; redirects flush the queue and reload the PC.
module fetch_pair_unit
    import fetch_pair_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_pair_unit_if.master bus
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push;
    logic [1:0]        pop;
    logic [CNT_W-1:0]  count;
    q_entry_t          wr0, wr1, rd0, rd1;

    // Push looks only at the pre-pop count so decode's take never reaches the fetch path.
    always_comb begin
        push = fetch_en && !redirect && (count <= CNT_W'(QDEPTH - 2));
        pop  = 2'd0;
        if (!redirect) begin
            pop = (CNT_W'(bus.dec_take) > count) ? count[1:0] : bus.dec_take;
        end
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + PAIR_STEP;
        end
        wr0 = '{pc: pc_q,           instr: bus.imem_rd1};
        wr1 = '{pc: pc_q + PC_STEP, instr: bus.imem_rd2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_pair_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wr0   (wr0),
        .wr1   (wr1),
        .pop   (pop),
        .rd0   (rd0),
        .rd1   (rd1),
        .count (count)
    );

    assign bus.imem_a1    = pc_q;
    assign bus.imem_a2    = pc_q + PC_STEP;
    assign bus.dec_valid0 = (count != '0);
    assign bus.dec_valid1 = (count >= CNT_W'(2));
    assign bus.dec_instr0 = rd0.instr;
    assign bus.dec_pc0    = rd0.pc;
    assign bus.dec_instr1 = rd1.instr;
    assign bus.dec_pc1    = rd1.pc;

`ifndef SYNTHESIS
    // Decode may not over-consume, and redirect targets must be word aligned.
    always @(posedge clk) begin
        if (rst_n && !redirect) begin
            assert (CNT_W'(bus.dec_take) <= count);
        end
        if (rst_n && redirect) begin
            assert (redirect_pc[1:0] == 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pair_unit.sv
// Self-checking bench for fetch_pair_unit against a queue-based reference model.
module tb_fetch_pair_unit;
    import fetch_pair_unit_pkg::*;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];

    fetch_pair_unit_if bus();

    fetch_pair_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always_comb begin
        bus.imem_rd1 = mem_word(bus.imem_a1);
        bus.imem_rd2 = mem_word(bus.imem_a2);
    end

    task automatic model_reset();
        m_pc = 32'h0;
        mq_pc.delete();
        mq_ins.delete();
    endtask

    // One clock: drive at negedge, apply the rules to the model at posedge, return at next negedge.
    task automatic cycle(input logic fe, input logic [1:0] take, input logic rd, input logic [31:0] rpc);
        int n;
        fetch_en    = fe;
        bus.dec_take = take;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        if (rd) begin
            mq_pc.delete();
            mq_ins.delete();
            m_pc = rpc;
        end else begin
            n = mq_pc.size();
            repeat (int'(take)) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (fe && n <= QD - 2) begin
                mq_pc.push_back(m_pc);
                mq_ins.push_back(mem_word(m_pc));
                mq_pc.push_back(m_pc + 32'd4);
                mq_ins.push_back(mem_word(m_pc + 32'd4));
                m_pc = m_pc + 32'd8;
            end
        end
        @(negedge clk);
        bus.dec_take = 2'd0;
        redirect     = 1'b0;
    endtask

    task automatic steer_to_three();
        for (int i = 0; i < 8 && mq_pc.size() != 3; i++) begin
            if (mq_pc.size() > 3) cycle(1'b0, 2'd1, 1'b0, 32'h0);
            else                  cycle(1'b1, 2'd0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (bus.imem_a1 !== 32'h0 || bus.imem_a2 !== 32'h4) begin
            n_bad++;
            $display("[TB] FAIL reset_addr got %h/%h want 00000000/00000004", bus.imem_a1, bus.imem_a2);
        end
        n_cmp++;
        if (bus.dec_valid0 !== 1'b0 || bus.dec_valid1 !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_valid got %b%b want 00", bus.dec_valid0, bus.dec_valid1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        logic [31:0] exp_a1 [3];
        exp_a1[0] = 32'h8; exp_a1[1] = 32'h10; exp_a1[2] = 32'h10;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'd0, 1'b0, 32'h0);
            n_cmp++;
            if (bus.imem_a1 !== exp_a1[i] || bus.imem_a2 !== exp_a1[i] + 32'd4) begin
                n_bad++;
                $display("[TB] FAIL fill_addr step %0d got %h/%h want %h/%h", i, bus.imem_a1, bus.imem_a2,
                         exp_a1[i], exp_a1[i] + 32'd4);
            end
            n_cmp++;
            if (bus.dec_valid0 !== 1'b1 || bus.dec_valid1 !== 1'b1 || bus.dec_pc0 !== 32'h0 || bus.dec_pc1 !== 32'h4
                || bus.dec_instr0 !== mem_word(32'h0) || bus.dec_instr1 !== mem_word(32'h4)) begin
                n_bad++;
                $display("[TB] FAIL fill_head step %0d got v=%b%b pc=%h/%h want v=11 pc=00000000/00000004", i,
                         bus.dec_valid0, bus.dec_valid1, bus.dec_pc0, bus.dec_pc1);
            end
        end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 2'd2, 1'b0, 32'h0);
            n_cmp++;
            if (bus.dec_valid0 !== 1'b1 || bus.dec_valid1 !== 1'b1 || mq_pc.size() < 2) begin
                n_bad++;
                $display("[TB] FAIL steady_bubble step %0d got v=%b%b want v=11", i, bus.dec_valid0, bus.dec_valid1);
            end else begin
                n_cmp++;
                if (bus.dec_pc0 !== mq_pc[0] || bus.dec_pc1 !== mq_pc[1] || bus.dec_instr0 !== mq_ins[0]
                    || bus.dec_instr1 !== mq_ins[1]) begin
                    n_bad++;
                    $display("[TB] FAIL steady_data step %0d got pc=%h/%h want %h/%h", i, bus.dec_pc0, bus.dec_pc1,
                             mq_pc[0], mq_pc[1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int sz;
        logic [1:0] take;
        steer_to_three();
        for (int i = 0; i < 12; i++) begin
            sz   = mq_pc.size();
            take = (i % 2 == 0) ? 2'd1 : 2'd2;
            if (int'(take) > sz) take = 2'(sz);
            cycle(1'b1, take, 1'b0, 32'h0);
            n_cmp++;
            if (bus.dec_valid0 !== (mq_pc.size() >= 1) || bus.dec_valid1 !== (mq_pc.size() >= 2)) begin
                n_bad++;
                $display("[TB] FAIL wrap_valid step %0d got v=%b%b want count %0d", i, bus.dec_valid0,
                         bus.dec_valid1, mq_pc.size());
            end
            if (mq_pc.size() >= 2) begin
                n_cmp++;
                if (bus.dec_pc0 !== mq_pc[0] || bus.dec_pc1 !== bus.dec_pc0 + 32'd4 || bus.dec_instr0 !== mq_ins[0]
                    || bus.dec_instr1 !== mq_ins[1]) begin
                    n_bad++;
                    $display("[TB] FAIL wrap_order step %0d got pc=%h/%h want %h/%h", i, bus.dec_pc0, bus.dec_pc1,
                             mq_pc[0], mq_pc[1]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        steer_to_three();
        cycle(1'b1, 2'd2, 1'b1, 32'h24);
        n_cmp++;
        if (bus.dec_valid0 !== 1'b0 || bus.dec_valid1 !== 1'b0 || bus.imem_a1 !== 32'h24 || bus.imem_a2 !== 32'h28) begin
            n_bad++;
            $display("[TB] FAIL redirect_flush got v=%b%b a=%h/%h want v=00 a=00000024/00000028", bus.dec_valid0,
                     bus.dec_valid1, bus.imem_a1, bus.imem_a2);
        end
        cycle(1'b1, 2'd0, 1'b0, 32'h0);
        n_cmp++;
        if (bus.dec_valid0 !== 1'b1 || bus.dec_pc0 !== 32'h24 || bus.dec_instr0 !== mem_word(32'h24)
            || bus.dec_valid1 !== 1'b1 || bus.dec_pc1 !== 32'h28) begin
            n_bad++;
            $display("[TB] FAIL redirect_refetch got v=%b pc0=%h pc1=%h want v=1 pc0=00000024 pc1=00000028",
                     bus.dec_valid0, bus.dec_pc0, bus.dec_pc1);
        end
    endtask

    task automatic test_fetch_disable();
        logic [31:0] frozen;
        steer_to_three();
        frozen = m_pc;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd1, 1'b0, 32'h0);
            n_cmp++;
            if (bus.imem_a1 !== frozen || bus.dec_valid0 !== (i < 2) || bus.dec_valid1 !== (i < 1)) begin
                n_bad++;
                $display("[TB] FAIL disable_drain step %0d got a1=%h v=%b%b want a1=%h v=%b%b", i, bus.imem_a1,
                         bus.dec_valid0, bus.dec_valid1, frozen, (i < 2), (i < 1));
            end
        end
    endtask

    task automatic test_pc_wrap();
        cycle(1'b1, 2'd0, 1'b1, 32'hFFFF_FFF8);
        n_cmp++;
        if (bus.imem_a1 !== 32'hFFFF_FFF8 || bus.imem_a2 !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("[TB] FAIL pcwrap_load got %h/%h want fffffff8/fffffffc", bus.imem_a1, bus.imem_a2);
        end
        cycle(1'b1, 2'd0, 1'b0, 32'h0);
        n_cmp++;
        if (bus.imem_a1 !== 32'h0 || bus.dec_pc0 !== 32'hFFFF_FFF8 || bus.dec_pc1 !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("[TB] FAIL pcwrap_next got a1=%h pc=%h/%h want 00000000 fffffff8/fffffffc", bus.imem_a1,
                     bus.dec_pc0, bus.dec_pc1);
        end
    endtask

    task automatic test_random();
        int sz;
        logic fe, rd;
        logic [1:0] take;
        logic [31:0] rpc;
        for (int i = 0; i < 300; i++) begin
            sz   = mq_pc.size();
            fe   = ($urandom_range(0, 3) != 0);
            take = 2'($urandom_range(0, (sz > 2) ? 2 : sz));
            rd   = ($urandom_range(0, 15) == 0);
            rpc  = $urandom();
            rpc[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            cycle(fe, take, rd, rpc);
            n_cmp++;
            if (bus.imem_a1 !== m_pc || bus.imem_a2 !== m_pc + 32'd4) begin
                n_bad++;
                $display("[TB] FAIL rand_addr cyc %0d got %h/%h want %h/%h", i, bus.imem_a1, bus.imem_a2, m_pc,
                         m_pc + 32'd4);
            end
            n_cmp++;
            if (bus.dec_valid0 !== (mq_pc.size() >= 1) || bus.dec_valid1 !== (mq_pc.size() >= 2)) begin
                n_bad++;
                $display("[TB] FAIL rand_valid cyc %0d got v=%b%b want count %0d", i, bus.dec_valid0,
                         bus.dec_valid1, mq_pc.size());
            end
            if (mq_pc.size() >= 1) begin
                n_cmp++;
                if (bus.dec_pc0 !== mq_pc[0] || bus.dec_instr0 !== mq_ins[0]) begin
                    n_bad++;
                    $display("[TB] FAIL rand_head0 cyc %0d got %h:%h want %h:%h", i, bus.dec_pc0, bus.dec_instr0,
                             mq_pc[0], mq_ins[0]);
                end
            end
            if (mq_pc.size() >= 2) begin
                n_cmp++;
                if (bus.dec_pc1 !== mq_pc[1] || bus.dec_instr1 !== mq_ins[1]) begin
                    n_bad++;
                    $display("[TB] FAIL rand_head1 cyc %0d got %h:%h want %h:%h", i, bus.dec_pc1, bus.dec_instr1,
                             mq_pc[1], mq_ins[1]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        steer_to_three();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.dec_valid0 !== 1'b0 || bus.dec_valid1 !== 1'b0 || bus.imem_a1 !== 32'h0 || bus.imem_a2 !== 32'h4) begin
            n_bad++;
            $display("[TB] FAIL async_reset got v=%b%b a=%h/%h want v=00 a=00000000/00000004", bus.dec_valid0,
                     bus.dec_valid1, bus.imem_a1, bus.imem_a2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 2'd0, 1'b0, 32'h0);
        n_cmp++;
        if (bus.imem_a1 !== 32'h8 || bus.dec_pc0 !== 32'h0 || bus.dec_pc1 !== 32'h4
            || bus.dec_instr0 !== mem_word(32'h0)) begin
            n_bad++;
            $display("[TB] FAIL async_restart got a1=%h pc=%h/%h want 00000008 00000000/00000004", bus.imem_a1,
                     bus.dec_pc0, bus.dec_pc1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.dec_take = 2'd0;
        model_reset();
        test_reset();
        test_fill();
        test_steady();
        test_wrap();
        test_redirect();
        test_fetch_disable();
        test_pc_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
